// File: rtl/exec_task_dispatcher_if.sv
// ---------------------------------------------------------------------------
// exec_task_dispatcher_if
//   Bundles the task-queue handshake and the shared cluster start/done bus
//   that surround exec_task_dispatcher.
//   Signals:
//     task_valid  queue -> dispatcher   task_in is valid
//     task_ready  dispatcher -> queue   task_in accepted this cycle
//     task_in     queue -> dispatcher   complete task, top bits = cluster id
//     exec_start  dispatcher -> clusters  one-cycle start pulse per cluster
//     exec_task   dispatcher -> clusters  reduced task, shared by all clusters
//     exec_done   clusters -> dispatcher  per-cluster op_done pulse
//   Modports: slave = dispatcher side, master = environment side.
// ---------------------------------------------------------------------------
interface exec_task_dispatcher_if #(
    parameter int unsigned CLUSTER_NUM = 7,
    parameter int unsigned TASK_W      = 72,
    parameter int unsigned TASK_R_W    = 68
);
    logic                   task_valid;
    logic                   task_ready;
    logic [TASK_W-1:0]      task_in;
    logic [CLUSTER_NUM-1:0] exec_start;
    logic [TASK_R_W-1:0]    exec_task;
    logic [CLUSTER_NUM-1:0] exec_done;

    modport slave (
        input  task_valid, task_in, exec_done,
        output task_ready, exec_start, exec_task
    );

    modport master (
        output task_valid, task_in, exec_done,
        input  task_ready, exec_start, exec_task
    );
endinterface

// File: rtl/exec_task_dispatcher.sv
// ---------------------------------------------------------------------------
// exec_task_dispatcher
//   In-order scheduler from the task queue to CLUSTER_NUM execution clusters.
//   Decodes the cluster id from the top bits of each task, issues the reduced
//   task with a one-cycle start pulse, tracks per-cluster busy state, honours
//   a barrier id (wait for all clusters idle) and flags malformed ids.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     bus           exec_task_dispatcher_if.slave (task handshake + cluster bus)
//     busy          cluster i holds an issued, unfinished task
//     all_idle      FSM idle and no cluster busy
//     err_bad_id    sticky flag: a task with an invalid id was dropped
//     stall_cycles  blocked/waiting cycle counter
//   Optional feature macro: DISPATCH_PERF_CNT_EN enables the stall_cycles
//   counter; when undefined stall_cycles is tied to zero.
// ---------------------------------------------------------------------------
module exec_task_dispatcher #(
    parameter int unsigned CLUSTER_NUM = 7,
    parameter int unsigned TASK_W      = 72,
    parameter int unsigned TASK_R_W    = 68,
    parameter logic [3:0]  BARRIER_ID  = 4'hF
) (
    input  logic                   clk,
    input  logic                   rst,
    exec_task_dispatcher_if.slave  bus,
    output logic [CLUSTER_NUM-1:0] busy,
    output logic                   all_idle,
    output logic                   err_bad_id,
    output logic [31:0]            stall_cycles
);
    localparam int unsigned ID_W = TASK_W - TASK_R_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CHECK   = 2'd1,
        S_BARRIER = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [TASK_W-1:0]      hold_q, hold_d;
    logic [CLUSTER_NUM-1:0] start_q, start_d;
    logic [CLUSTER_NUM-1:0] busy_q, busy_d;
    logic [TASK_R_W-1:0]    xtask_q, xtask_d;
    logic                   err_q, err_d;

    logic [ID_W-1:0]        id_c;
    logic [CLUSTER_NUM-1:0] id_onehot_c;
    logic                   id_ok_c;
    logic                   id_free_c;

    // Id decode of the held task; ids past the cluster range shift out to zero.
    assign id_c        = hold_q[TASK_W-1:TASK_R_W];
    assign id_onehot_c = CLUSTER_NUM'(1) << id_c;
    assign id_ok_c     = (id_c < ID_W'(CLUSTER_NUM));
    assign id_free_c   = id_ok_c && ((busy_q & id_onehot_c) == '0);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            start_q <= '0;
            busy_q  <= '0;
            xtask_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            xtask_q <= xtask_d;
            err_q   <= err_d;
        end
    end

    // Next-state and issue logic; decisions look only at registered busy.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        start_d = '0;
        xtask_d = xtask_q;
        err_d   = err_q;
        // Done on an idle cluster clears nothing, so spurious pulses are harmless.
        busy_d  = busy_q & ~bus.exec_done;

        case (state_q)
            S_IDLE: begin
                if (bus.task_valid) begin
                    hold_d  = bus.task_in;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (id_ok_c) begin
                    if (id_free_c) begin
                        start_d = id_onehot_c;
                        xtask_d = hold_q[TASK_R_W-1:0];
                        busy_d  = busy_d | id_onehot_c;
                        state_d = S_IDLE;
                    end
                end else if (id_c == ID_W'(BARRIER_ID)) begin
                    state_d = S_BARRIER;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_BARRIER: begin
                if (busy_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.task_ready = (state_q == S_IDLE);
    assign bus.exec_start = start_q;
    assign bus.exec_task  = xtask_q;
    assign busy           = busy_q;
    assign all_idle       = (state_q == S_IDLE) && (busy_q == '0);
    assign err_bad_id     = err_q;

`ifdef DISPATCH_PERF_CNT_EN
    logic        stall_c;
    logic [31:0] stall_q;

    // Blocked check on a busy cluster, or barrier still waiting for drains.
    assign stall_c = ((state_q == S_CHECK) && id_ok_c && !id_free_c) ||
                     ((state_q == S_BARRIER) && (busy_q != '0));

    // Saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (stall_c && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_exec_task_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_exec_task_dispatcher
//   Directed self-checking bench for exec_task_dispatcher. Inputs change and
//   outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_exec_task_dispatcher;
    logic        clk;
    logic        rst;
    logic [6:0]  busy;
    logic        all_idle;
    logic        err_bad_id;
    logic [31:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

`ifdef DISPATCH_PERF_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd9;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    exec_task_dispatcher_if #(.CLUSTER_NUM(7), .TASK_W(72), .TASK_R_W(68)) bus ();

    exec_task_dispatcher #(
        .CLUSTER_NUM(7),
        .TASK_W     (72),
        .TASK_R_W   (68),
        .BARRIER_ID (4'hF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .busy        (busy),
        .all_idle    (all_idle),
        .err_bad_id  (err_bad_id),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one task; returns at the falling edge of the following S_CHECK cycle.
    task automatic put(input logic [3:0] id, input logic [67:0] pl);
        chk("ready_before_put", 128'(bus.task_ready), 128'(1'b1));
        bus.task_valid = 1'b1;
        bus.task_in    = {id, pl};
        tick();
        bus.task_valid = 1'b0;
        bus.task_in    = '0;
    endtask

    task automatic done_pulse(input logic [6:0] m);
        bus.exec_done = m;
        tick();
        bus.exec_done = '0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.task_valid = 1'b0;
        bus.task_in    = '0;
        bus.exec_done  = '0;
        tick();
        tick();

        // Reset state
        chk("rst_start",    128'(bus.exec_start), 128'(7'b0));
        chk("rst_task",     128'(bus.exec_task),  128'(68'h0));
        chk("rst_busy",     128'(busy),           128'(7'b0));
        chk("rst_all_idle", 128'(all_idle),       128'(1'b1));
        chk("rst_err",      128'(err_bad_id),     128'(1'b0));
        chk("rst_stall",    128'(stall_cycles),   128'(32'd0));
        rst = 1'b0;
        tick();

        // 1: single issue to cluster 2, then completion
        put(4'd2, 68'hABC);
        chk("t1_ready_in_check", 128'(bus.task_ready), 128'(1'b0));
        chk("t1_no_early_start", 128'(bus.exec_start), 128'(7'b0));
        tick();
        chk("t1_start",    128'(bus.exec_start), 128'(7'b0000100));
        chk("t1_task",     128'(bus.exec_task),  128'(68'hABC));
        chk("t1_busy",     128'(busy),           128'(7'b0000100));
        chk("t1_ready",    128'(bus.task_ready), 128'(1'b1));
        chk("t1_not_idle", 128'(all_idle),       128'(1'b0));
        tick();
        chk("t1_start_1cyc", 128'(bus.exec_start), 128'(7'b0));
        chk("t1_task_hold",  128'(bus.exec_task),  128'(68'hABC));
        done_pulse(7'b0000100);
        chk("t1_busy_clr", 128'(busy),     128'(7'b0));
        chk("t1_all_idle", 128'(all_idle), 128'(1'b1));

        // 2: head-of-line block on cluster 0; done sampled 10 edges after start
        put(4'd0, 68'h1111);
        tick();
        chk("t2_start1", 128'(bus.exec_start), 128'(7'b0000001));
        put(4'd0, 68'h2222);
        for (int i = 0; i < 8; i++) begin
            chk("t2_stall_ready", 128'(bus.task_ready), 128'(1'b0));
            chk("t2_stall_start", 128'(bus.exec_start), 128'(7'b0));
            tick();
        end
        bus.exec_done = 7'b0000001;
        tick();
        bus.exec_done = '0;
        chk("t2_done+1_start", 128'(bus.exec_start), 128'(7'b0));
        chk("t2_done+1_ready", 128'(bus.task_ready), 128'(1'b0));
        tick();
        chk("t2_start2", 128'(bus.exec_start), 128'(7'b0000001));
        chk("t2_task2",  128'(bus.exec_task),  128'(68'h2222));
        chk("t2_stall",  128'(stall_cycles),   128'(EXP_STALL));
        done_pulse(7'b0000001);

        // 3: ids 1 and 5 in flight, barrier, then id 3 held until all drained
        put(4'd1, 68'h0101);
        tick();
        put(4'd5, 68'h0505);
        tick();
        chk("t3_busy_pre", 128'(busy), 128'(7'b0100010));
        put(4'hF, 68'h0);
        tick();
        for (int c = 0; c <= 40; c++) begin
            bus.exec_done  = (c == 20) ? 7'b0100000 : (c == 30) ? 7'b0000010 : 7'b0;
            bus.task_valid = (c <= 32);
            bus.task_in    = {4'h3, 68'h333};
            chk("t3_start", 128'(bus.exec_start), 128'((c == 34) ? 7'b0001000 : 7'b0));
            if (c == 10) chk("t3_barrier_ready", 128'(bus.task_ready), 128'(1'b0));
            if (c == 32) chk("t3_ready_after_drain", 128'(bus.task_ready), 128'(1'b1));
            if (c == 34) chk("t3_busy", 128'(busy), 128'(7'b0001000));
            tick();
        end
        bus.task_valid = 1'b0;
        bus.task_in    = '0;
        bus.exec_done  = '0;
        done_pulse(7'b0001000);

        // 4: bad id 9 dropped, sticky error, next task issues normally
        put(4'd9, 68'h999);
        chk("t4_ready_check", 128'(bus.task_ready), 128'(1'b0));
        tick();
        chk("t4_err",   128'(err_bad_id),     128'(1'b1));
        chk("t4_ready", 128'(bus.task_ready), 128'(1'b1));
        chk("t4_start", 128'(bus.exec_start), 128'(7'b0));
        chk("t4_busy",  128'(busy),           128'(7'b0));
        put(4'd4, 68'h444);
        tick();
        chk("t4_start4", 128'(bus.exec_start), 128'(7'b0010000));
        chk("t4_task4",  128'(bus.exec_task),  128'(68'h444));
        chk("t4_err_sticky", 128'(err_bad_id), 128'(1'b1));
        done_pulse(7'b0010000);

        // 5: spurious done, then reset while blocked in S_CHECK
        done_pulse(7'b1000000);
        chk("t5_spur_busy", 128'(busy),       128'(7'b0));
        chk("t5_spur_idle", 128'(all_idle),   128'(1'b1));
        chk("t5_spur_err",  128'(err_bad_id), 128'(1'b1));
        put(4'd2, 68'h55);
        tick();
        put(4'd2, 68'h66);
        tick();
        chk("t5_blocked_ready", 128'(bus.task_ready), 128'(1'b0));
        chk("t5_blocked_busy",  128'(busy),           128'(7'b0000100));
        rst = 1'b1;
        #1;
        chk("t5_rst_busy",  128'(busy),           128'(7'b0));
        chk("t5_rst_start", 128'(bus.exec_start), 128'(7'b0));
        chk("t5_rst_task",  128'(bus.exec_task),  128'(68'h0));
        chk("t5_rst_err",   128'(err_bad_id),     128'(1'b0));
        chk("t5_rst_ready", 128'(bus.task_ready), 128'(1'b1));
        chk("t5_rst_idle",  128'(all_idle),       128'(1'b1));
        chk("t5_rst_stall", 128'(stall_cycles),   128'(32'd0));
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_post_rst_start", 128'(bus.exec_start), 128'(7'b0));
            chk("t5_post_rst_ready", 128'(bus.task_ready), 128'(1'b1));
        end

        // 6: done on cluster 0 and issue to cluster 1 on the same edge
        put(4'd0, 68'hA0);
        tick();
        chk("t6_busy0",  128'(busy),           128'(7'b0000001));
        chk("t6_start0", 128'(bus.exec_start), 128'(7'b0000001));
        put(4'd1, 68'hB1);
        bus.exec_done = 7'b0000001;
        tick();
        bus.exec_done = '0;
        chk("t6_busy_swap", 128'(busy),           128'(7'b0000010));
        chk("t6_start1",    128'(bus.exec_start), 128'(7'b0000010));
        chk("t6_task1",     128'(bus.exec_task),  128'(68'hB1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
